vga_timing_gen: RTL

Generates 640x480@60 Hz VGA timing from vga_clk (25.175 MHz nominal) and drives the monitor pins: hsync, vsync and 12-bit RGB. It is the stage upstream of the BRAM image display stage. It issues pixel_xpos and pixel_ypos far enough ahead that the returned pixel_data lands exactly on the active-video window.

---
 rtl/vga_timing_gen.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA timing generator with pixel request lead for a downstream BRAM stage.
// Optional colour-bar source selected by `define VGA_TEST_PATTERN_EN.
module vga_timing_gen #(
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BACK   = 48,
  parameter int unsigned H_DISP   = 640,
  parameter int unsigned H_FRONT  = 16,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 33,
  parameter int unsigned V_DISP   = 480,
  parameter int unsigned V_FRONT  = 10,
  parameter int unsigned PIPE_DLY = 2
) (
  input  logic        vga_clk,
  input  logic        rst_n,
  input  logic [11:0] pixel_data,
  output logic [9:0]  pixel_xpos,
  output logic [9:0]  pixel_ypos,
  output logic        data_req,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic [11:0] vga_rgb,
  output logic        frame_start
);

  localparam int unsigned CW      = 11;
  localparam int unsigned PW      = 10;
  localparam int unsigned RGB_W   = 12;
  localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam int unsigned HA      = H_SYNC + H_BACK;
  localparam int unsigned VA      = V_SYNC + V_BACK;

  localparam logic [CW-1:0] C_H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] C_V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] C_H_SYNC = CW'(H_SYNC);
  localparam logic [CW-1:0] C_V_SYNC = CW'(V_SYNC);
  localparam logic [CW-1:0] C_HA     = CW'(HA);
  localparam logic [CW-1:0] C_HA_END = CW'(HA + H_DISP);
  localparam logic [CW-1:0] C_VA     = CW'(VA);
  localparam logic [CW-1:0] C_VA_END = CW'(VA + V_DISP);
  localparam logic [CW-1:0] C_RQ     = CW'(HA - PIPE_DLY);
  localparam logic [CW-1:0] C_RQ_END = CW'(HA + H_DISP - PIPE_DLY);

  logic [PW-1:0]    r_h_cnt;
  logic [PW-1:0]    r_v_cnt;
  logic [PW-1:0]    w_h_nxt;
  logic [PW-1:0]    w_v_nxt;
  logic [CW-1:0]    w_h;
  logic [CW-1:0]    w_v;
  logic             w_h_act;
  logic             w_v_act;
  logic             w_de;
  logic             w_req;
  logic             w_hs;
  logic             w_vs;
  logic             w_fs;
  logic [PW-1:0]    w_xpos;
  logic [PW-1:0]    w_ypos;
  logic [RGB_W-1:0] w_rgb_src;

  assign w_h = {1'b0, r_h_cnt};
  assign w_v = {1'b0, r_v_cnt};

  // Raster counters: v_cnt advances (and wraps) on the h_cnt wrap edge.
  always_comb begin
    w_h_nxt = r_h_cnt + PW'(1);
    w_v_nxt = r_v_cnt;
    if (w_h == C_H_LAST) begin
      w_h_nxt = '0;
      if (w_v == C_V_LAST) begin
        w_v_nxt = '0;
      end else begin
        w_v_nxt = r_v_cnt + PW'(1);
      end
    end
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else begin
      r_h_cnt <= w_h_nxt;
      r_v_cnt <= w_v_nxt;
    end
  end

  // Decode of the current counter values; registered below.
  always_comb begin
    w_hs    = 1'b1;
    w_vs    = 1'b1;
    w_h_act = 1'b0;
    w_v_act = 1'b0;
    w_de    = 1'b0;
    w_req   = 1'b0;
    w_fs    = 1'b0;
    w_xpos  = '0;
    w_ypos  = '0;
    if (w_h < C_H_SYNC) w_hs = 1'b0;
    if (w_v < C_V_SYNC) w_vs = 1'b0;
    w_h_act = (w_h >= C_HA) && (w_h < C_HA_END);
    w_v_act = (w_v >= C_VA) && (w_v < C_VA_END);
    w_de    = w_h_act && w_v_act;
    w_req   = (w_h >= C_RQ) && (w_h < C_RQ_END) && w_v_act;
    w_fs    = (w_h == '0) && (w_v == '0);
    // Window bounds keep both differences non-negative.
    if (w_req) begin
      w_xpos = PW'(w_h - C_RQ);
      w_ypos = PW'(w_v - C_VA);
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned BAR_W = H_DISP / 8;

  logic [CW-1:0]    w_col;
  logic [2:0]       w_bar;
  logic             w_unused_pix;

  assign w_unused_pix = ^pixel_data;

  // Bar index from the active column against boundaries 0, 80, ..., 560.
  always_comb begin
    w_col     = w_h - C_HA;
    w_bar     = '0;
    w_rgb_src = '0;
    for (int i = 1; i < 8; i++) begin
      if (w_col >= CW'(i * BAR_W)) w_bar = 3'(i);
    end
    case (w_bar)
      3'd0:    w_rgb_src = 12'hFFF;
      3'd1:    w_rgb_src = 12'hFF0;
      3'd2:    w_rgb_src = 12'h0FF;
      3'd3:    w_rgb_src = 12'h0F0;
      3'd4:    w_rgb_src = 12'hF0F;
      3'd5:    w_rgb_src = 12'hF00;
      3'd6:    w_rgb_src = 12'h00F;
      default: w_rgb_src = 12'h000;
    endcase
  end
`else
  assign w_rgb_src = pixel_data;
`endif

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_de      <= 1'b0;
      vga_rgb     <= '0;
      data_req    <= 1'b0;
      pixel_xpos  <= '0;
      pixel_ypos  <= '0;
      frame_start <= 1'b0;
    end else begin
      vga_hs      <= w_hs;
      vga_vs      <= w_vs;
      vga_de      <= w_de;
      vga_rgb     <= w_de ? w_rgb_src : '0;
      data_req    <= w_req;
      pixel_xpos  <= w_xpos;
      pixel_ypos  <= w_ypos;
      frame_start <= w_fs;
    end
  end

endmodule
